// File: rtl/wisard_addr_gen_if.sv
// Port bundle for wisard_addr_gen: sample input handshake plus the classifier sink beat bus.
// A sample moves on a rising clk edge where in_valid && in_ready; the sink side has no backpressure.
interface wisard_addr_gen_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int INDEX_WIDTH   = 7,
    parameter int N_RAMS        = 98
);
    localparam int INPUT_WIDTH = N_RAMS * ADDRESS_WIDTH;

    logic                     in_valid;
    logic                     in_ready;
    logic [INPUT_WIDTH-1:0]   in_data;
    logic                     sop;
    logic                     sink_valid;
    logic                     eop;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [INDEX_WIDTH-1:0]   index;
    logic                     busy;

    modport slave (
        input  in_valid, in_data,
        output in_ready, sop, sink_valid, eop, addr, index, busy
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, sop, sink_valid, eop, addr, index, busy
    );
endinterface

// File: rtl/wisard_addr_gen.sv
// WiSARD address generator: ping-pong buffers binarized samples and streams one
// interleaved RAM address per cycle, framed with sop/eop.
module wisard_addr_gen #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int INDEX_WIDTH   = 7,
    parameter int N_RAMS        = 98
) (
    input  logic             clk,
    input  logic             rst,
    wisard_addr_gen_if.slave bus,
    output logic             state_dbg
);
    localparam int INPUT_WIDTH = N_RAMS * ADDRESS_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(N_RAMS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [INPUT_WIDTH-1:0]   buf_q [2];
    logic [1:0]               full_q;
    logic                     wr_ptr_q;
    logic                     rd_ptr_q;
    logic [INDEX_WIDTH-1:0]   cnt_q;
    logic [INDEX_WIDTH-1:0]   cnt_d;
    logic                     accept;
    logic                     beat;
    logic                     last;
    logic [INPUT_WIDTH-1:0]   rd_buf;
    logic [N_RAMS-1:0]        lane;
    logic [N_RAMS-1:0]        lane_sh;
    logic [ADDRESS_WIDTH-1:0] addr_d;

    // in_ready depends on registered state only, so an upstream can never see a same-cycle bypass.
    assign bus.in_ready = !full_q[wr_ptr_q];
    assign bus.busy     = full_q[0] | full_q[1] | bus.sink_valid;
    assign state_dbg    = state_q;

    always_comb begin
        accept  = bus.in_valid && !full_q[wr_ptr_q];
        beat    = full_q[rd_ptr_q];
        last    = beat && (cnt_q == LAST_IDX);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (beat)  state_d = STREAM;
            STREAM:  if (!beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (beat) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
        // Address bit k of beat i comes from the k-th N_RAMS-wide lane of the sample.
        rd_buf  = buf_q[rd_ptr_q];
        lane    = '0;
        lane_sh = '0;
        addr_d  = '0;
        for (int k = 0; k < ADDRESS_WIDTH; k++) begin
            lane      = rd_buf[k*N_RAMS +: N_RAMS];
            lane_sh   = lane >> cnt_q;
            addr_d[k] = lane_sh[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0]       <= '0;
            buf_q[1]       <= '0;
            full_q         <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            cnt_q          <= '0;
            bus.sop        <= 1'b0;
            bus.sink_valid <= 1'b0;
            bus.eop        <= 1'b0;
            bus.addr       <= '0;
            bus.index      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                buf_q[wr_ptr_q]  <= bus.in_data;
                full_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            // The draining buffer is full, so it can never be the one being written here.
            if (last) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= ~rd_ptr_q;
            end
            bus.sink_valid <= beat;
            bus.sop        <= beat && (cnt_q == '0);
            bus.eop        <= last;
            if (beat) begin
                bus.addr  <= addr_d;
                bus.index <= cnt_q;
            end
        end
    end
endmodule

// File: tb/tb_wisard_addr_gen.sv
// Bench for wisard_addr_gen: scoreboard of expected beats (with their expected clock edge)
// derived from a buffer-occupancy model, plus a one-RAM instance for the single-beat case.
module tb_wisard_addr_gen;
  localparam int AW  = 2;
  localparam int IW  = 2;
  localparam int NR  = 4;
  localparam int IWD = NR * AW;
  localparam int AW1 = 8;
  localparam int IW1 = 1;
  localparam int NR1 = 1;
  localparam int BW  = 16 + 2 + IW + AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wisard_addr_gen_if #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .N_RAMS(NR)) bus ();
  wisard_addr_gen_if #(.ADDRESS_WIDTH(AW1), .INDEX_WIDTH(IW1), .N_RAMS(NR1)) bus1 ();
  logic state_dbg;
  logic state_dbg1;

  wisard_addr_gen #(.ADDRESS_WIDTH(AW), .INDEX_WIDTH(IW), .N_RAMS(NR)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );
  wisard_addr_gen #(.ADDRESS_WIDTH(AW1), .INDEX_WIDTH(IW1), .N_RAMS(NR1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state_dbg1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {edge[15:0], sop, eop, index, addr}; st_q/end_q hold each sample's beat window
  logic [BW-1:0] exp_q[$];
  int st_q[$];
  int end_q[$];
  int model_end = -10;
  int last_acc  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  function automatic logic [AW-1:0] ref_addr(input logic [IWD-1:0] d, input int i);
    logic [AW-1:0] a;
    for (int k = 0; k < AW; k++) a[k] = d[k*NR + i];
    return a;
  endfunction

  // A sample accepted at edge a streams on consecutive edges once the previous one has finished.
  task automatic model_accept(input logic [IWD-1:0] d, input int a);
    int start;
    start = (a + 1 > model_end + 1) ? a + 1 : model_end + 1;
    model_end = start + NR - 1;
    st_q.push_back(start);
    end_q.push_back(model_end);
    for (int i = 0; i < NR; i++)
      exp_q.push_back({16'(start + i), i == 0, i == NR - 1, IW'(i), ref_addr(d, i)});
  endtask

  task automatic model_flush();
    exp_q.delete();
    st_q.delete();
    end_q.delete();
    model_end = -10;
  endtask

  // Called between a posedge and the following negedge; returns just after the accepting edge.
  task automatic send(input logic [IWD-1:0] d);
    int guard;
    logic ok;
    guard = 0;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      guard++;
    end while (!ok && guard < 200);
    #1;
    if (ok) begin
      last_acc = cyc;
      model_accept(d, cyc);
    end else begin
      timeout("send_accept");
    end
    bus.in_valid = 1'b0;
    bus.in_data  = IWD'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || end_q.size() != 0) && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sink_valid"}, 32'(bus.sink_valid), 32'd0);
    check({tag, "_sop"},        32'(bus.sop),        32'd0);
    check({tag, "_eop"},        32'(bus.eop),        32'd0);
    check({tag, "_busy"},       32'(bus.busy),       32'd0);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, "_index"},      32'(bus.index),      32'd0);
    check({tag, "_addr"},       32'(bus.addr),       32'd0);
    check({tag, "_state"},      32'(state_dbg),      32'd0);
  endtask

  // Monitor: every cycle compare handshake/framing against the model and pop each beat.
  always @(negedge clk) begin
    int n_pend;
    logic exp_v;
    logic [BW-1:0] e;
    if (!rst) begin
      while (end_q.size() > 0 && end_q[0] < cyc) begin
        void'(end_q.pop_front());
        void'(st_q.pop_front());
      end
      n_pend = 0;
      exp_v  = 1'b0;
      foreach (end_q[i]) begin
        if (end_q[i] > cyc) n_pend++;
        if (st_q[i] <= cyc && cyc <= end_q[i]) exp_v = 1'b1;
      end
      check("sink_valid", 32'(bus.sink_valid), 32'(exp_v));
      check("in_ready",   32'(bus.in_ready),   32'(n_pend < 2));
      check("busy",       32'(bus.busy),       32'(end_q.size() > 0));
      if (bus.sink_valid) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_beat");
        end else begin
          e = exp_q.pop_front();
          check("beat_edge",  32'(cyc[15:0]),  32'(e[BW-1 -: 16]));
          check("beat_sop",   32'(bus.sop),    32'(e[AW+IW+1]));
          check("beat_eop",   32'(bus.eop),    32'(e[AW+IW]));
          check("beat_index", 32'(bus.index),  32'(e[AW+IW-1:AW]));
          check("beat_addr",  32'(bus.addr),   32'(e[AW-1:0]));
        end
      end else begin
        check("idle_sop", 32'(bus.sop), 32'd0);
        check("idle_eop", 32'(bus.eop), 32'd0);
      end
    end
  end

  task automatic single_ram(input logic [7:0] d);
    int guard;
    int acc;
    logic ok;
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    guard = 0;
    ok = 1'b0;
    do begin
      @(negedge clk);
      ok = bus1.in_ready;
      @(posedge clk);
      guard++;
    end while (!ok && guard < 50);
    #1;
    acc = cyc;
    bus1.in_valid = 1'b0;
    if (!ok) begin
      timeout("one_accept");
    end else begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!bus1.sink_valid && guard < 20);
      if (!bus1.sink_valid) begin
        timeout("one_beat");
      end else begin
        check("one_edge",  32'(cyc),           32'(acc + 1));
        check("one_sop",   32'(bus1.sop),      32'd1);
        check("one_eop",   32'(bus1.eop),      32'd1);
        check("one_index", 32'(bus1.index),    32'd0);
        check("one_addr",  32'(bus1.addr),     32'(d));
        @(negedge clk);
        check("one_after", 32'(bus1.sink_valid), 32'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish (t=%0t)", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int acc1;
    int idx_guard;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;

    // reset state, then a second reset pulse while idle
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst_init");
    rst = 1'b0;
    idle(4);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_idle");
    idle(2);
    #2;
    rst = 1'b0;
    idle(2);

    // single sample with known interleave result 2,3,0,2
    send(8'b1011_0010);
    drain();

    // three back-to-back offers: third accepted one edge after the first eop
    send(IWD'($urandom));
    acc1 = last_acc;
    send(IWD'($urandom));
    check("second_accept", 32'(last_acc), 32'(acc1 + 1));
    send(IWD'($urandom));
    check("third_accept", 32'(last_acc), 32'(acc1 + 5));
    drain();

    // two samples with a 10-cycle idle gap
    send(IWD'($urandom));
    idle(10);
    check("gap_busy", 32'(bus.busy), 32'd0);
    send(IWD'($urandom));
    drain();

    // reset while the index-2 beat is on the outputs
    send(IWD'($urandom));
    idx_guard = 0;
    do begin
      @(negedge clk);
      idx_guard++;
    end while (!(bus.sink_valid && bus.index == IW'(2)) && idx_guard < 20);
    if (idx_guard >= 20) timeout("wait_index2");
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_flush();
    idle(2);
    #2;
    rst = 1'b0;
    idle(1);
    send(IWD'($urandom));
    drain();

    // randomized traffic with random gaps
    repeat (40) begin
      idle($urandom_range(0, 3));
      send(IWD'($urandom));
    end
    drain();

    // single-RAM configuration
    single_ram(8'hA5);
    repeat (4) single_ram(8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
